// File: rtl/mac_relu_unit_if.sv
// mac_relu_unit_if: operand/result bundle of the MAC + ReLU datapath.
// The engine side drives operands and control; the datapath drives results.
interface mac_relu_unit_if #(
    parameter int DATA_W = 32
);
    logic              clr;
    logic              enable;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] relu_acc;
    logic              busy;
    logic              ovf;

    modport master (
        output clr, enable, a, b,
        input  acc, relu_acc, busy, ovf
    );

    modport slave (
        input  clr, enable, a, b,
        output acc, relu_acc, busy, ovf
    );
endinterface

// File: rtl/mac_relu_unit.sv
// mac_relu_unit: 3-stage signed multiply-accumulate with saturating
// output and combinational ReLU; controlled only by enable and clr.
module mac_relu_unit #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48
) (
    input logic             clk,
    input logic             rst,
    mac_relu_unit_if.slave  bus
);
    localparam int PW = 2 * DATA_W;
    localparam int EW = (PW > ACC_W) ? PW : ACC_W;

    localparam logic [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] DAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] a_q, b_q;
    logic signed [PW-1:0]     p_q, p_d;
    logic                     v1_q, v2_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     ovf_q;

    logic signed [EW-1:0]     p_ext;
    logic                     p_fits;
    logic        [ACC_W-1:0]  p_acc;
    logic        [ACC_W-1:0]  sum;
    logic                     add_ovf;
    logic [ACC_W-DATA_W:0]    hi_bits;
    logic                     in_range;
    logic [DATA_W-1:0]        acc_sat;

    // Full-width signed product of the registered operands.
    always_comb begin
        p_d = PW'(a_q) * PW'(b_q);
    end

    // Fit the product into the accumulator; an out-of-range product is
    // clamped to the accumulator limit so the sign of the result survives.
    always_comb begin
        p_ext   = EW'(p_q);
        p_fits  = (p_ext == EW'($signed(p_ext[ACC_W-1:0])));
        p_acc   = p_fits ? p_ext[ACC_W-1:0]
                         : (p_q[PW-1] ? ACC_MIN : ACC_MAX);
        sum     = acc_q + p_acc;
        add_ovf = (acc_q[ACC_W-1] == p_acc[ACC_W-1])
               && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end

    // Saturate the wide accumulator down to the output width.
    always_comb begin
        hi_bits  = acc_q[ACC_W-1:DATA_W-1];
        in_range = (&hi_bits) | ~(|hi_bits);
        if (in_range) begin
            acc_sat = acc_q[DATA_W-1:0];
        end else if (acc_q[ACC_W-1]) begin
            acc_sat = DAT_MIN;
        end else begin
            acc_sat = DAT_MAX;
        end
    end

    // Output drive: rectified value and status.
    always_comb begin
        bus.acc      = acc_sat;
        bus.relu_acc = acc_sat[DATA_W-1] ? '0 : acc_sat;
        bus.busy     = v1_q | v2_q;
        bus.ovf      = ovf_q | ~in_range;
    end

    // S1/S2: operand and product registers; clr kills both valids.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q  <= '0;
            b_q  <= '0;
            p_q  <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            p_q  <= p_d;
            v1_q <= bus.enable & ~bus.clr;
            v2_q <= v1_q & ~bus.clr;
        end
    end

    // S3: accumulate valid products; ovf is sticky until clr or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (bus.clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (v2_q) begin
                acc_q <= sum;
            end
            ovf_q <= ovf_q | ~in_range
                   | (v2_q & (add_ovf | ~p_fits));
        end
    end
endmodule

// File: tb/tb_mac_relu_unit.sv
// tb_mac_relu_unit: directed vector table plus hand-written sequences
// for reset, clear priority and saturation.
module tb_mac_relu_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        logic        clr;
        logic        en;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] acc;
        logic [31:0] relu;
        logic        busy;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    mac_relu_unit_if #(.DATA_W(32)) bus ();

    mac_relu_unit #(
        .DATA_W(32),
        .ACC_W (48)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] acc,
                             input logic [31:0] relu, input logic busy,
                             input logic ovf);
        check({tag, " acc"}, bus.acc, acc);
        check({tag, " relu"}, bus.relu_acc, relu);
        check({tag, " busy"}, {31'd0, bus.busy}, {31'd0, busy});
        check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, ovf});
    endtask

    task automatic drive(input logic c, input logic e,
                         input logic [31:0] a, input logic [31:0] b);
        bus.clr    = c;
        bus.enable = e;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic c, input logic e,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] acc,
                                input logic [31:0] relu,
                                input logic busy, input logic ovf);
        vecs.push_back('{c, e, a, b, acc, relu, busy, ovf});
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.clr    = 1'b0;
        bus.enable = 1'b0;
        bus.a      = '0;
        bus.b      = '0;

        // 3x3 edge kernel, sum 46
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 5, 32'hFFFFFFFF, 0, 0, 1, 0);
        add(0, 1, 7, 32'hFFFFFFFF, 0, 0, 1, 0);
        add(0, 1, 2, 32'hFFFFFFFF, 32'hFFFFFFFB, 0, 1, 0);
        add(0, 1, 9, 0, 32'hFFFFFFF4, 0, 1, 0);
        add(0, 1, 9, 0, 32'hFFFFFFF2, 0, 1, 0);
        add(0, 1, 9, 0, 32'hFFFFFFF2, 0, 1, 0);
        add(0, 1, 10, 1, 32'hFFFFFFF2, 0, 1, 0);
        add(0, 1, 20, 1, 32'hFFFFFFF2, 0, 1, 0);
        add(0, 1, 30, 1, 32'hFFFFFFFC, 0, 1, 0);
        add(0, 0, 0, 0, 16, 16, 1, 0);
        add(0, 0, 0, 0, 46, 46, 0, 0);
        add(0, 0, 0, 0, 46, 46, 0, 0);
        // negative sum -30
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 10, 32'hFFFFFFFF, 0, 0, 1, 0);
        add(0, 1, 10, 32'hFFFFFFFF, 0, 0, 1, 0);
        add(0, 1, 10, 32'hFFFFFFFF, 32'hFFFFFFF6, 0, 1, 0);
        add(0, 0, 0, 0, 32'hFFFFFFEC, 0, 1, 0);
        add(0, 0, 0, 0, 32'hFFFFFFE2, 0, 0, 0);
        // enable gaps with garbage operands
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 3, 4, 0, 0, 1, 0);
        add(0, 0, 99, 99, 0, 0, 1, 0);
        add(0, 0, 32'hFFFFFFF9, 55, 12, 12, 0, 0);
        add(0, 1, 2, 5, 12, 12, 1, 0);
        add(0, 0, 77, 3, 12, 12, 1, 0);
        add(0, 0, 0, 0, 22, 22, 0, 0);
        add(0, 0, 0, 0, 22, 22, 0, 0);

        // reset state
        @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].en, vecs[i].a, vecs[i].b);
            check_all($sformatf("vec%0d", i), vecs[i].acc, vecs[i].relu,
                      vecs[i].busy, vecs[i].ovf);
        end

        // clear priority: continuous (1,1) stream, one-cycle clr
        drive(1, 0, 0, 0);
        for (int n = 1; n <= 6; n++) drive(0, 1, 1, 1);
        check("clrp pre", bus.acc, 4);
        drive(1, 1, 1, 1);
        check_all("clrp edge", 0, 0, 0, 0);
        drive(0, 1, 1, 1);
        check("clrp +1", bus.acc, 0);
        drive(0, 1, 1, 1);
        check("clrp +2", bus.acc, 0);
        drive(0, 1, 1, 1);
        check("clrp +3", bus.acc, 1);
        drive(0, 1, 1, 1);
        check("clrp +4", bus.acc, 2);

        // positive saturation from an oversized product
        drive(1, 0, 0, 0);
        drive(0, 1, 32'h7FFFFFFF, 32'h7FFFFFFF);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check_all("satpos", 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("satpos sticky", {31'd0, bus.ovf}, 1);
        drive(1, 0, 0, 0);
        check_all("satpos clr", 0, 0, 0, 0);

        // negative saturation from an oversized product
        drive(0, 1, 32'h80000000, 32'h7FFFFFFF);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check_all("satneg", 32'h80000000, 0, 0, 1);

        // saturation of the output only (product fits the accumulator)
        drive(1, 0, 0, 0);
        drive(0, 1, 32'h40000000, 2);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check_all("satout", 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 1);

        // asynchronous reset mid-stream
        drive(1, 0, 0, 0);
        drive(0, 1, 123, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("rst pre acc", bus.acc, 123);
        drive(0, 1, 1, 1);
        check("rst pre busy", {31'd0, bus.busy}, 1);
        #3;
        rst = 1'b0;
        #1;
        check_all("rst async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("rst held", 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check_all("rst after", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
